unit_b_sequencer: RTL
=====================

# unit_b_sequencer

Control sequencer for one convolution unit of type B: weight memory, 25-tap weight FIFO, 25-tap convolution, accumulator and ReLU. For every filter slice and input-depth slice it does three things in order: it streams 25 kernel weights from weight memory into the weight FIFO, it paces window-by-window convolution against an upstream window source, and it times the accumulate, ReLU and output strobes. It sits between the layer top-level controller (start/done) and one unit datapath; one instance drives one unit.

## Interface
Parameters:
- ARITH_TYPE, 0: passed through for package consistency; no effect on sequencing.
- IFM_DEPTH, 6: input feature-map channels per filter.
- KERNAL_SIZE, 5: kernel edge; KERNAL_SIZE*KERNAL_SIZE must equal 25.
- NUMBER_OF_FILTERS, 16: total filters in the layer.
- NUMBER_OF_UNITS, 1: units sharing the filters.
- OFM_POSITIONS, 100: output windows per channel (10x10).
- CONV_LATENCY, 4: cycles from conv_enable to valid conv_data_out.
- CEIL_FILTERS, ceil(NUMBER_OF_FILTERS/NUMBER_OF_UNITS): derived.
- ADDRESS_SIZE_WM, clog2(25*IFM_DEPTH*CEIL_FILTERS): derived.

Ports:
- clk, input, 1: clock; single clock domain.
- reset, input, 1: synchronous, active-high.
- start, input, 1: one-cycle job request; only honoured in IDLE.
- window_valid, input, 1: upstream signal_if1..25 hold a valid window.
- window_ready, output, 1: sequencer accepts a window this cycle.
- wm_enable_read, output, 1: weight memory read strobe.
- wm_address, output, ADDRESS_SIZE_WM: weight memory read address.
- wm_fifo_enable, output, 1: shifts the weight FIFO.
- conv_enable, output, 1: launches the convolution.
- accu_enable, output, 1: accumulator captures.
- first_depth, output, 1: accumulate selects data_bias; otherwise data_in_from_next.
- relu_enable, output, 1: ReLU active; asserted only on the last depth.
- psum_addr, output, clog2(OFM_POSITIONS): partial-sum location for the current accumulate.
- out_valid, output, 1: unit_data_out is valid (final value when last depth, partial sum otherwise).
- busy, output, 1: not IDLE.
- done, output, 1: one-cycle pulse at job end.

## Operation
- Counters: f (0..CEIL_FILTERS-1), d (0..IFM_DEPTH-1), k (0..24), p (0..OFM_POSITIONS-1), drain counter.
- IDLE: start moves the sequencer to LOAD_W. f, d, k and p clear; wm_address clears to 0.
- LOAD_W:
  - 25 cycles with wm_enable_read=1 and wm_address incrementing.
  - wm_fifo_enable is wm_enable_read delayed by one cycle, matching the one-cycle memory read latency.
  - The state exits to COMPUTE after the last FIFO shift.
  - wm_address is never cleared between kernels. It runs 0..25*IFM_DEPTH*CEIL_FILTERS-1 and wraps to 0 at job end.
- COMPUTE:
  - window_ready=1.
  - conv_enable = window_valid & window_ready, combinational. The handshake increments p.
  - After the handshake at p=OFM_POSITIONS-1, the state moves to DRAIN.
- DRAIN:
  - Holds CONV_LATENCY+1 cycles so that no convolution is in flight while the FIFO shifts.
  - Then d increments and the state returns to LOAD_W. When d wraps, f increments. When f wraps, the state moves to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Accumulate pipeline:
  - A CONV_LATENCY-deep shift register carries {valid, p, d==0, d==IFM_DEPTH-1}.
  - Its output drives accu_enable, psum_addr, first_depth and relu_enable.
  - out_valid is accu_enable delayed by one cycle.
- start while busy: ignored.
- reset at any time: IDLE; all outputs and the pipeline valid bits go to 0 on the next edge; in-flight results are discarded.

## Timing
- Reset value: every output is 0.
- start sampled at edge 0:
  - wm_enable_read high in cycles 1..25, with address 0..24.
  - wm_fifo_enable high in cycles 2..26.
  - COMPUTE from cycle 27.
- conv_enable at cycle t gives accu_enable at t+CONV_LATENCY and out_valid at t+CONV_LATENCY+1.
- Back-to-back windows: one per cycle while window_valid stays high. A low window_valid stalls p.
- Job length with window_valid held high: CEIL_FILTERS*IFM_DEPTH*(25+1+OFM_POSITIONS+CONV_LATENCY+1) + 2 cycles, from start to the cycle after done.
- The last accu_enable of the job occurs during the final DRAIN, before done.

## Structure
- Shared package:
  - state enum {IDLE, LOAD_W, COMPUTE, DRAIN, DONE};
  - the localparam 25 (KERNAL_TAPS);
  - the CEIL_FILTERS and ADDRESS_SIZE_WM derivation functions. These are also used by the unit top.
- One sub-module: unit_b_seq_delay, a parameterised valid+payload shift register with synchronous reset. It is used for the accumulate pipeline and the one-cycle wm_fifo_enable / out_valid delays.

## Test plan
Bench parameters: IFM_DEPTH=2, CEIL_FILTERS=2, OFM_POSITIONS=3, CONV_LATENCY=4.
- Reset, then start at cycle 0 with window_valid=1: wm_address 0..24 in cycles 1..25; wm_fifo_enable in cycles 2..26; conv_enable in cycles 27..29; accu_enable in cycles 31..33 with psum_addr 0,1,2 and first_depth=1.
- Full job with window_valid=1: 12 conv_enable pulses; 12 accu_enable pulses; relu_enable only on the 6 with d=1; last wm_address is 99; done after 2*2*(26+3+5)+1 cycles.
- window_valid toggled 1,0,1,0 in COMPUTE: conv_enable only on the high cycles; p never skips; accu_enable spacing mirrors conv_enable spacing.
- start pulsed again mid-job: no effect; counters and wm_address unchanged; exactly one done.
- reset asserted in cycle 28 (COMPUTE, one window in flight): all outputs 0 from cycle 29; no accu_enable at cycle 32; a fresh start restarts at wm_address 0.
- Second job after done: wm_address restarts at 0; outputs identical to the first job.

Source files
------------

// File: rtl/unit_b_sequencer_pkg.sv
// Shared types, constants and parameter derivations for the type-B unit sequencer.
package unit_b_sequencer_pkg;

    localparam int unsigned KERNAL_TAPS = 25;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        COMPUTE,
        DRAIN,
        DONE
    } seq_state_e;

    // Bit width needed to index n values, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Filters handled by one unit when the layer is split across units.
    function automatic int unsigned ceil_filters(input int unsigned filters,
                                                 input int unsigned units);
        return (filters + units - 1) / units;
    endfunction

    // Weight-memory address width covering every kernel tap of every slice.
    function automatic int unsigned addr_size_wm(input int unsigned depth,
                                                 input int unsigned ceil_f);
        return clog2_min1(KERNAL_TAPS * depth * ceil_f);
    endfunction

endpackage

// File: rtl/unit_b_seq_delay.sv
// Valid + payload shift register with synchronous reset.
module unit_b_seq_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             delayed_valid,
    output logic [WIDTH-1:0] delayed_data
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Shift valid and payload one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid;
            data_q[0]  <= data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign delayed_valid = valid_q[DEPTH-1];
    assign delayed_data  = data_q[DEPTH-1];

endmodule

// File: rtl/unit_b_sequencer.sv
// Control sequencer for one type-B convolution unit: weight load, windowed
// convolution pacing and accumulate/ReLU/output strobe timing.
module unit_b_sequencer
    import unit_b_sequencer_pkg::*;
#(
    parameter int          ARITH_TYPE        = 0,
    parameter int unsigned IFM_DEPTH         = 6,
    parameter int unsigned KERNAL_SIZE       = 5,
    parameter int unsigned NUMBER_OF_FILTERS = 16,
    parameter int unsigned NUMBER_OF_UNITS   = 1,
    parameter int unsigned OFM_POSITIONS     = 100,
    parameter int unsigned CONV_LATENCY      = 4,
    parameter int unsigned CEIL_FILTERS      = ceil_filters(NUMBER_OF_FILTERS, NUMBER_OF_UNITS),
    parameter int unsigned ADDRESS_SIZE_WM   = addr_size_wm(IFM_DEPTH, CEIL_FILTERS)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    window_valid,
    output logic                                    window_ready,
    output logic                                    wm_enable_read,
    output logic [ADDRESS_SIZE_WM-1:0]              wm_address,
    output logic                                    wm_fifo_enable,
    output logic                                    conv_enable,
    output logic                                    accu_enable,
    output logic                                    first_depth,
    output logic                                    relu_enable,
    output logic [clog2_min1(OFM_POSITIONS)-1:0]    psum_addr,
    output logic                                    out_valid,
    output logic                                    busy,
    output logic                                    done
);

    localparam int unsigned P_W    = clog2_min1(OFM_POSITIONS);
    localparam int unsigned F_W    = clog2_min1(CEIL_FILTERS);
    localparam int unsigned D_W    = clog2_min1(IFM_DEPTH);
    localparam int unsigned K_W    = clog2_min1(KERNAL_TAPS + 1);
    localparam int unsigned DR_W   = clog2_min1(CONV_LATENCY + 1);
    localparam int unsigned PIPE_W = P_W + 2;

    // Reject kernel shapes the 25-tap datapath cannot hold.
    if (KERNAL_SIZE * KERNAL_SIZE != KERNAL_TAPS || ARITH_TYPE < 0) begin : g_bad_params
        $error("unit_b_sequencer: unsupported KERNAL_SIZE or ARITH_TYPE");
    end

    seq_state_e                 state_q, state_d;
    logic [F_W-1:0]             f_q, f_d;
    logic [D_W-1:0]             d_q, d_d;
    logic [K_W-1:0]             k_q, k_d;
    logic [P_W-1:0]             p_q, p_d;
    logic [DR_W-1:0]            drain_q, drain_d;
    logic [ADDRESS_SIZE_WM-1:0] addr_q, addr_d;
    logic                       rd_q, rd_d;

    logic [PIPE_W-1:0]          pipe_in;
    logic [PIPE_W-1:0]          pipe_out;
    logic                       fifo_data_unused;
    logic                       out_data_unused;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            f_q     <= '0;
            d_q     <= '0;
            k_q     <= '0;
            p_q     <= '0;
            drain_q <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            d_q     <= d_d;
            k_q     <= k_d;
            p_q     <= p_d;
            drain_q <= drain_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
        end
    end

    assign window_ready   = (state_q == COMPUTE);
    assign conv_enable    = window_valid & window_ready;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign wm_enable_read = rd_q;
    assign wm_address     = addr_q;

    // Next-state and counter sequencing across load, compute and drain.
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        d_d     = d_q;
        k_d     = k_q;
        p_d     = p_q;
        drain_d = drain_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    f_d     = '0;
                    d_d     = '0;
                    k_d     = '0;
                    p_d     = '0;
                    addr_d  = '0;
                end
            end
            LOAD_W: begin
                if (k_q < K_W'(KERNAL_TAPS)) begin
                    k_d    = k_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end else begin
                    state_d = COMPUTE;
                    p_d     = '0;
                end
            end
            COMPUTE: begin
                if (conv_enable) begin
                    if (p_q == P_W'(OFM_POSITIONS - 1)) begin
                        state_d = DRAIN;
                        p_d     = '0;
                        drain_d = '0;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DR_W'(CONV_LATENCY)) begin
                    k_d = '0;
                    if (d_q == D_W'(IFM_DEPTH - 1)) begin
                        d_d = '0;
                        if (f_q == F_W'(CEIL_FILTERS - 1)) begin
                            f_d     = '0;
                            addr_d  = '0;
                            state_d = DONE;
                        end else begin
                            f_d     = f_q + 1'b1;
                            state_d = LOAD_W;
                        end
                    end else begin
                        d_d     = d_q + 1'b1;
                        state_d = LOAD_W;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_d = (state_d == LOAD_W) && (k_d < K_W'(KERNAL_TAPS));
    end

    // Payload is zeroed for idle slots so accumulate-side outputs stay low between windows.
    assign pipe_in = conv_enable ? {p_q, (d_q == '0), (d_q == D_W'(IFM_DEPTH - 1))}
                                 : '0;

    unit_b_seq_delay #(
        .DEPTH (CONV_LATENCY),
        .WIDTH (PIPE_W)
    ) u_accu_pipe (
        .clk           (clk),
        .reset         (reset),
        .valid         (conv_enable),
        .data          (pipe_in),
        .delayed_valid (accu_enable),
        .delayed_data  (pipe_out)
    );

    assign psum_addr   = pipe_out[PIPE_W-1:2];
    assign first_depth = pipe_out[1];
    assign relu_enable = pipe_out[0];

    unit_b_seq_delay #(
        .DEPTH (1),
        .WIDTH (1)
    ) u_fifo_dly (
        .clk           (clk),
        .reset         (reset),
        .valid         (rd_q),
        .data          (1'b0),
        .delayed_valid (wm_fifo_enable),
        .delayed_data  (fifo_data_unused)
    );

    unit_b_seq_delay #(
        .DEPTH (1),
        .WIDTH (1)
    ) u_out_dly (
        .clk           (clk),
        .reset         (reset),
        .valid         (accu_enable),
        .data          (1'b0),
        .delayed_valid (out_valid),
        .delayed_data  (out_data_unused)
    );

endmodule
